// File: rtl/derived_clock_bank_if.sv
// Bus bundle for derived_clock_bank: per-channel controls in, square waves / strobes / pending flags out.
// Handshake: no valid/ready; load and sync are single-cycle strobes sampled on every rising clk edge.
interface derived_clock_bank_if #(
  parameter int NCH = 4,
  parameter int CW  = 32
);
  logic [NCH-1:0]    enable;
  logic [NCH-1:0]    load;
  logic [NCH*CW-1:0] half_period;
  logic [NCH*CW-1:0] phase;
  logic              sync;
  logic [NCH-1:0]    out;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    pending;

  modport master (
    output enable, load, half_period, phase, sync,
    input  out, tick, pending
  );

  modport slave (
    input  enable, load, half_period, phase, sync,
    output out, tick, pending
  );
endinterface

// File: rtl/derived_clock_bank.sv
// Bank of NCH programmable 50%-duty clock dividers with shadowed half-period reload and common sync.
// Optional macro DERIVED_CLOCK_BANK_PHASE_EN: sync preloads each counter with min(phase, hp).
module derived_clock_bank #(
  parameter int            NCH      = 4,
  parameter int            CW       = 32,
  parameter logic [CW-1:0] RESET_HP = '0
) (
  input  logic               clk,
  input  logic               rst,
  derived_clock_bank_if.slave bus
);
  logic [CW-1:0]  cnt_q    [NCH];
  logic [CW-1:0]  cnt_d    [NCH];
  logic [CW-1:0]  hp_q     [NCH];
  logic [CW-1:0]  hp_d     [NCH];
  logic [CW-1:0]  shadow_q [NCH];
  logic [CW-1:0]  shadow_d [NCH];
  logic [CW-1:0]  sync_hp  [NCH];
  logic [NCH-1:0] out_q, out_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] pending_q, pending_d;

  always_comb begin
    cnt_d     = cnt_q;
    hp_d      = hp_q;
    shadow_d  = shadow_q;
    out_d     = out_q;
    tick_d    = '0;
    pending_d = pending_q;
    for (int i = 0; i < NCH; i++) begin
      // Half-period in force after a sync: fresh load beats shadow, shadow beats current.
      sync_hp[i] = bus.load[i] ? bus.half_period[i*CW +: CW]
                 : (pending_q[i] ? shadow_q[i] : hp_q[i]);
      if (!bus.enable[i]) begin
        cnt_d[i] = '0;
        out_d[i] = 1'b0;
        if (pending_q[i]) hp_d[i] = shadow_q[i];
        pending_d[i] = bus.load[i];
        if (bus.load[i]) shadow_d[i] = bus.half_period[i*CW +: CW];
      end else if (bus.sync) begin
        hp_d[i]      = sync_hp[i];
        pending_d[i] = 1'b0;
        out_d[i]     = 1'b0;
        if (bus.load[i]) shadow_d[i] = bus.half_period[i*CW +: CW];
`ifdef DERIVED_CLOCK_BANK_PHASE_EN
        cnt_d[i] = (bus.phase[i*CW +: CW] > sync_hp[i]) ? sync_hp[i] : bus.phase[i*CW +: CW];
`else
        cnt_d[i] = '0;
`endif
      end else begin
        if (cnt_q[i] == hp_q[i]) begin
          cnt_d[i]  = '0;
          out_d[i]  = ~out_q[i];
          tick_d[i] = 1'b1;
          if (pending_q[i]) begin
            hp_d[i]      = shadow_q[i];
            pending_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
        // A load landing on a wrap stays pending for the following boundary.
        if (bus.load[i]) begin
          shadow_d[i]  = bus.half_period[i*CW +: CW];
          pending_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]    <= '0;
        hp_q[i]     <= RESET_HP;
        shadow_q[i] <= RESET_HP;
      end
      out_q     <= '0;
      tick_q    <= '0;
      pending_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hp_q      <= hp_d;
      shadow_q  <= shadow_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.tick    = tick_q;
  assign bus.pending = pending_q;
endmodule

// File: tb/tb_derived_clock_bank.sv
// Self-checking bench for derived_clock_bank: directed scenarios plus randomized traffic
// compared each cycle against a countdown-to-toggle reference model.
module tb_derived_clock_bank;
  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int W   = 3 * NCH;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  derived_clock_bank_if #(.NCH(NCH), .CW(CW)) bus ();

  derived_clock_bank #(.NCH(NCH), .CW(CW), .RESET_HP('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: cycles left until the next toggle, level, pending shadow
  longint         m_hp     [NCH];
  longint         m_shadow [NCH];
  longint         m_left   [NCH];
  logic [NCH-1:0] m_out, m_tick, m_pend;
  logic [W-1:0]   exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_hp[i] = 0; m_shadow[i] = 0; m_left[i] = 1;
    end
    m_out = '0; m_tick = '0; m_pend = '0;
    exp_q.delete();
  endtask

  // driver: advance model with current inputs, clock once, settle
  task automatic step();
    for (int i = 0; i < NCH; i++) begin
      longint sl, ph, off;
      sl = longint'(bus.half_period[i*CW +: CW]);
      ph = longint'(bus.phase[i*CW +: CW]);
      if (!bus.enable[i]) begin
        if (m_pend[i]) m_hp[i] = m_shadow[i];
        m_pend[i] = 1'b0;
        if (bus.load[i]) begin m_shadow[i] = sl; m_pend[i] = 1'b1; end
        m_out[i] = 1'b0; m_tick[i] = 1'b0; m_left[i] = m_hp[i] + 1;
      end else if (bus.sync) begin
        if (bus.load[i]) begin m_hp[i] = sl; m_shadow[i] = sl; end
        else if (m_pend[i]) m_hp[i] = m_shadow[i];
        m_pend[i] = 1'b0;
        m_out[i] = 1'b0; m_tick[i] = 1'b0;
        off = 0;
`ifdef DERIVED_CLOCK_BANK_PHASE_EN
        off = (ph < m_hp[i]) ? ph : m_hp[i];
`endif
        m_left[i] = m_hp[i] + 1 - off;
      end else begin
        m_left[i] = m_left[i] - 1;
        m_tick[i] = 1'b0;
        if (m_left[i] == 0) begin
          m_out[i] = ~m_out[i]; m_tick[i] = 1'b1;
          if (m_pend[i]) begin m_hp[i] = m_shadow[i]; m_pend[i] = 1'b0; end
          m_left[i] = m_hp[i] + 1;
        end
        if (bus.load[i]) begin m_shadow[i] = sl; m_pend[i] = 1'b1; end
      end
    end
    exp_q.push_back({m_out, m_tick, m_pend});
    @(posedge clk);
    #1;
  endtask

  task automatic set_hp(input int ch, input int val);
    bus.half_period[ch*CW +: CW] = CW'(val);
  endtask

  task automatic idle_inputs();
    bus.enable = '0; bus.load = '0; bus.sync = 1'b0;
    bus.half_period = '0; bus.phase = '0;
  endtask

  task automatic test_reset();
    logic [W-1:0] got;
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    got = {bus.out, bus.tick, bus.pending};
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL reset_state got %h exp %h", got, {W{1'b0}});
    end
    rst = 1'b0;
    step();
    got = {bus.out, bus.tick, bus.pending};
    checks++;
    if (got !== exp_q.pop_front()) begin
      errors++; $display("FAIL reset_release got %h", got);
    end
  endtask

  // ch0: load hp=3 while disabled, then run: toggle every 4 cycles
  task automatic test_basic();
    logic [W-1:0] got, exp;
    int ticks;
    idle_inputs();
    set_hp(0, 3); bus.load[0] = 1'b1;
    step(); void'(exp_q.pop_front());
    bus.load = '0;
    step(); void'(exp_q.pop_front());
    bus.enable[0] = 1'b1;
    ticks = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      got = {bus.out, bus.tick, bus.pending};
      exp = exp_q.pop_front();
      if (bus.tick[0]) ticks++;
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL basic cyc %0d got %h exp %h", c, got, exp);
      end
    end
    checks++;
    if (ticks !== 4) begin
      errors++; $display("FAIL basic_tick_count got %0d exp 4", ticks);
    end
  endtask

  // ch1 hp=4, reload hp=1 when cnt==2: current half completes 2 cycles later
  task automatic test_reload();
    logic [W-1:0] got, exp;
    int first;
    idle_inputs();
    set_hp(1, 4); bus.load[1] = 1'b1;
    step(); void'(exp_q.pop_front());
    bus.load = '0;
    step(); void'(exp_q.pop_front());
    bus.enable[1] = 1'b1;
    step(); void'(exp_q.pop_front());
    step(); void'(exp_q.pop_front());
    set_hp(1, 1); bus.load[1] = 1'b1;
    step(); void'(exp_q.pop_front());
    bus.load = '0;
    first = -1;
    for (int c = 1; c <= 8; c++) begin
      step();
      got = {bus.out, bus.tick, bus.pending};
      exp = exp_q.pop_front();
      if (first < 0 && bus.tick[1]) first = c;
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL reload cyc %0d got %h exp %h", c, got, exp);
      end
    end
    checks++;
    if (first !== 2) begin
      errors++; $display("FAIL reload_first_tick got %0d exp 2", first);
    end
  endtask

  // hp=1,2,3,5 on all channels, sync: first ticks 2,3,4,6 cycles later
  task automatic test_sync();
    logic [W-1:0] got, exp;
    int first[NCH];
    int want[NCH];
    want = '{2, 3, 4, 6};
    idle_inputs();
    for (int i = 0; i < NCH; i++) set_hp(i, want[i] - 1);
    bus.load = '1;
    step(); void'(exp_q.pop_front());
    bus.load = '0;
    step(); void'(exp_q.pop_front());
    bus.enable = '1;
    repeat ($urandom_range(3, 9)) begin step(); void'(exp_q.pop_front()); end
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    got = {bus.out, bus.tick, bus.pending};
    exp = exp_q.pop_front();
    checks++;
    if (bus.out !== '0 || got !== exp) begin
      errors++; $display("FAIL sync_clear got %h exp %h", got, exp);
    end
    for (int i = 0; i < NCH; i++) first[i] = -1;
    for (int c = 1; c <= 8; c++) begin
      step();
      got = {bus.out, bus.tick, bus.pending};
      exp = exp_q.pop_front();
      for (int i = 0; i < NCH; i++) if (first[i] < 0 && bus.tick[i]) first[i] = c;
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL sync cyc %0d got %h exp %h", c, got, exp);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (first[i] !== want[i]) begin
        errors++; $display("FAIL sync_first_tick ch%0d got %0d exp %0d", i, first[i], want[i]);
      end
    end
  endtask

  // hp=0 on ch2: tick continuously high; dropping enable clears out/tick next cycle
  task automatic test_hp0_disable();
    logic [W-1:0] got, exp;
    idle_inputs();
    set_hp(2, 0); bus.load[2] = 1'b1;
    step(); void'(exp_q.pop_front());
    bus.load = '0;
    step(); void'(exp_q.pop_front());
    bus.enable[2] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      got = {bus.out, bus.tick, bus.pending};
      exp = exp_q.pop_front();
      checks++;
      if (bus.tick[2] !== 1'b1 || bus.out[2] !== ~c[0] || got !== exp) begin
        errors++; $display("FAIL hp0 cyc %0d got %h exp %h", c, got, exp);
      end
    end
    bus.enable[2] = 1'b0;
    step();
    got = {bus.out, bus.tick, bus.pending};
    exp = exp_q.pop_front();
    checks++;
    if (bus.out[2] !== 1'b0 || bus.tick[2] !== 1'b0 || got !== exp) begin
      errors++; $display("FAIL disable_clear got %h exp %h", got, exp);
    end
  endtask

  // ch3 hp=2: load on a wrap keeps pending; load with sync applies at once
  task automatic test_load_wrap_sync();
    logic [W-1:0] got, exp;
    int first;
    idle_inputs();
    set_hp(3, 2); bus.load[3] = 1'b1;
    step(); void'(exp_q.pop_front());
    bus.load = '0;
    step(); void'(exp_q.pop_front());
    bus.enable[3] = 1'b1;
    step(); void'(exp_q.pop_front());
    step(); void'(exp_q.pop_front());
    set_hp(3, 5); bus.load[3] = 1'b1;
    step();
    got = {bus.out, bus.tick, bus.pending};
    exp = exp_q.pop_front();
    checks++;
    if (bus.tick[3] !== 1'b1 || bus.pending[3] !== 1'b1 || got !== exp) begin
      errors++; $display("FAIL load_on_wrap got %h exp %h", got, exp);
    end
    set_hp(3, 1); bus.sync = 1'b1;
    step();
    bus.load = '0; bus.sync = 1'b0;
    got = {bus.out, bus.tick, bus.pending};
    exp = exp_q.pop_front();
    checks++;
    if (bus.pending[3] !== 1'b0 || bus.out[3] !== 1'b0 || got !== exp) begin
      errors++; $display("FAIL load_with_sync got %h exp %h", got, exp);
    end
    first = -1;
    for (int c = 1; c <= 5; c++) begin
      step();
      got = {bus.out, bus.tick, bus.pending};
      exp = exp_q.pop_front();
      if (first < 0 && bus.tick[3]) first = c;
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL after_sync cyc %0d got %h exp %h", c, got, exp);
      end
    end
    checks++;
    if (first !== 2) begin
      errors++; $display("FAIL sync_new_hp_tick got %0d exp 2", first);
    end
  endtask

`ifdef DERIVED_CLOCK_BANK_PHASE_EN
  // hp=7 with phase 5, 0, 9(clamped): first ticks 3, 8, 1 cycles after sync
  task automatic test_phase();
    logic [W-1:0] got, exp;
    int first[3];
    int want[3];
    want = '{3, 8, 1};
    idle_inputs();
    for (int i = 0; i < 3; i++) set_hp(i, 7);
    bus.load = 4'b0111;
    step(); void'(exp_q.pop_front());
    bus.load = '0;
    step(); void'(exp_q.pop_front());
    bus.enable = 4'b0111;
    bus.phase[0*CW +: CW] = CW'(5);
    bus.phase[1*CW +: CW] = CW'(0);
    bus.phase[2*CW +: CW] = CW'(9);
    step(); void'(exp_q.pop_front());
    bus.sync = 1'b1;
    step(); void'(exp_q.pop_front());
    bus.sync = 1'b0;
    for (int i = 0; i < 3; i++) first[i] = -1;
    for (int c = 1; c <= 10; c++) begin
      step();
      got = {bus.out, bus.tick, bus.pending};
      exp = exp_q.pop_front();
      for (int i = 0; i < 3; i++) if (first[i] < 0 && bus.tick[i]) first[i] = c;
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL phase cyc %0d got %h exp %h", c, got, exp);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (first[i] !== want[i]) begin
        errors++; $display("FAIL phase_first_tick ch%0d got %0d exp %0d", i, first[i], want[i]);
      end
    end
  endtask
`endif

  // largest half-period: first toggle after 2^CW cycles, no wraparound
  task automatic test_max_hp();
    logic [W-1:0] got, exp;
    int first;
    int second;
    idle_inputs();
    set_hp(0, (1 << CW) - 1); bus.load[0] = 1'b1;
    step(); void'(exp_q.pop_front());
    bus.load = '0;
    step(); void'(exp_q.pop_front());
    bus.enable[0] = 1'b1;
    first = -1; second = -1;
    for (int c = 1; c <= 2 * (1 << CW) + 4; c++) begin
      step();
      got = {bus.out, bus.tick, bus.pending};
      exp = exp_q.pop_front();
      if (bus.tick[0]) begin
        if (first < 0) first = c; else if (second < 0) second = c;
      end
      if (got !== exp) begin
        checks++; errors++;
        $display("FAIL max_hp cyc %0d got %h exp %h", c, got, exp);
      end
    end
    checks++;
    if (first !== (1 << CW) || second !== 2 * (1 << CW)) begin
      errors++; $display("FAIL max_hp_ticks got %0d,%0d exp %0d,%0d", first, second, 1 << CW, 2 * (1 << CW));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] got, exp;
    idle_inputs();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 14) == 0) bus.enable[i] = ~bus.enable[i];
        bus.load[i] = ($urandom_range(0, 9) == 0);
        set_hp(i, $urandom_range(0, 6));
        bus.phase[i*CW +: CW] = CW'($urandom_range(0, 9));
      end
      bus.sync = ($urandom_range(0, 24) == 0);
      step();
      got = {bus.out, bus.tick, bus.pending};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", c, got, exp);
      end
    end
  endtask

  // reset asserted between edges must clear outputs without a clock
  task automatic test_async_reset();
    logic [W-1:0] got;
    idle_inputs();
    bus.enable = '1;
    repeat (5) begin step(); void'(exp_q.pop_front()); end
    #2;
    rst = 1'b1;
    #1;
    got = {bus.out, bus.tick, bus.pending};
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL async_reset got %h exp %h", got, {W{1'b0}});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_reload();
    test_sync();
    test_hp0_disable();
    test_load_wrap_sync();
`ifdef DERIVED_CLOCK_BANK_PHASE_EN
    test_phase();
`endif
    test_max_hp();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
